// File: rtl/lsu.sv
// Load/store unit between the decoder and a word-wide data-memory bus.
// Loads answer in the second request cycle; stores follow the bus handshake.
module lsu #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_r_en_i,
    input  logic                  mem_wr_en_i,
    input  logic                  mem_r_sext_i,
    input  logic [1:0]            mem_acc_r_i,
    input  logic [1:0]            mem_acc_w_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic                  mem_wr_ready_o,
    output logic                  err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [31:0]           bus_wdata_o,
    input  logic                  bus_ready_i,
    input  logic [31:0]           bus_rdata_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        WR_REQ  = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BE_W-1:0]       wr_be;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_err;
    logic [1:0]            rd_off;
    logic [1:0]            rd_size;
    logic                  rd_sext;
    logic                  rd_err;

    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  rd_req_c;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    function automatic logic size_legal(input logic [1:0] size, input logic [1:0] o);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~o[0];
            2'b10:   return (o == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] size_be(input logic [1:0] size, input logic [1:0] o);
        case (size)
            2'b00:   return 4'b0001 << o;
            2'b01:   return 4'b0011 << o;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_rep(input logic [1:0] size, input logic [DATA_W-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign off       = addr_i[1:0];
    assign word_addr = {addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Read requests go out in the decoder's EXEC cycle; reset suppresses them at once.
    assign rd_req_c = (state == IDLE) && !rst_i && !mem_wr_en_i && mem_r_en_i
                      && size_legal(mem_acc_r_i, off);

    assign bus_req_o      = rd_req_c || (state == WR_REQ);
    assign bus_we_o       = (state == WR_REQ);
    assign mem_wr_ready_o = (state == WR_DONE);
    assign err_o          = ((state == WR_DONE) && wr_err) || ((state == RD_DATA) && rd_err);

    always_comb begin
        bus_addr_o  = '0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        if (state == WR_REQ) begin
            bus_addr_o  = wr_addr;
            bus_be_o    = wr_be;
            bus_wdata_o = wr_data;
        end else if (rd_req_c) begin
            bus_addr_o = word_addr;
            bus_be_o   = size_be(mem_acc_r_i, off);
        end
    end

    assign rd_byte = bus_rdata_i[{rd_off, 3'b000} +: 8];
    assign rd_half = bus_rdata_i[{rd_off[1], 4'b0000} +: 16];

    // Lane select and extension of the returning read word.
    always_comb begin
        rdata_o = '0;
        if ((state == RD_DATA) && !rd_err) begin
            case (rd_size)
                2'b00:   rdata_o = {{24{rd_sext & rd_byte[7]}}, rd_byte};
                2'b01:   rdata_o = {{16{rd_sext & rd_half[15]}}, rd_half};
                default: rdata_o = bus_rdata_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            wr_addr <= '0;
            wr_be   <= '0;
            wr_data <= '0;
            wr_err  <= 1'b0;
            rd_off  <= '0;
            rd_size <= '0;
            rd_sext <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_wr_en_i) begin
                        wr_addr <= word_addr;
                        wr_be   <= size_be(mem_acc_w_i, off);
                        wr_data <= lane_rep(mem_acc_w_i, wdata_i);
                        wr_err  <= !size_legal(mem_acc_w_i, off);
                        state   <= size_legal(mem_acc_w_i, off) ? WR_REQ : WR_DONE;
                    end else if (mem_r_en_i) begin
                        rd_off  <= off;
                        rd_size <= mem_acc_r_i;
                        rd_sext <= mem_r_sext_i;
                        rd_err  <= !size_legal(mem_acc_r_i, off);
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: state <= IDLE;
                WR_REQ: begin
                    if (bus_ready_i) begin
                        state <= WR_DONE;
                    end
                end
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: drivers push expected bus/response events,
// negedge monitors pop and compare them against what the DUT presents.
module tb_lsu;

    localparam int unsigned AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          mem_r_en_i = 1'b0;
    logic          mem_wr_en_i = 1'b0;
    logic          mem_r_sext_i = 1'b0;
    logic [1:0]    mem_acc_r_i = '0;
    logic [1:0]    mem_acc_w_i = '0;
    logic [AW-1:0] addr_i = '0;
    logic [31:0]   wdata_i = '0;
    logic [31:0]   rdata_o;
    logic          mem_wr_ready_o;
    logic          err_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [3:0]    bus_be_o;
    logic [31:0]   bus_wdata_o;
    logic          bus_ready_i = 1'b0;
    logic [31:0]   bus_rdata_i = '0;

    lsu #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_r_en_i(mem_r_en_i), .mem_wr_en_i(mem_wr_en_i),
        .mem_r_sext_i(mem_r_sext_i), .mem_acc_r_i(mem_acc_r_i), .mem_acc_w_i(mem_acc_w_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .mem_wr_ready_o(mem_wr_ready_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        bit          err;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int        checks = 0;
    int        errors = 0;
    bit        rd_phase2 = 1'b0;
    int        stall_cfg = 0;
    int        wr_seen = 0;
    int        cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: observed %h (t=%0t)", name, act, $time);
    endtask

    // Reference model: legality, byte enables, lane data and load extension.
    function automatic bit m_legal(input int size, input logic [31:0] a);
        if (size == 3) return 1'b0;
        return (a % (32'd1 << size)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input int size, input logic [31:0] a);
        int         nb;
        int         o;
        logic [3:0] be;
        nb = 1 << size;
        o  = int'(a % 4);
        be = '0;
        for (int i = 0; i < nb; i++) begin
            if (o + i < 4) be[o + i] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] d);
        int          nb;
        logic [31:0] w;
        nb = 1 << size;
        w  = '0;
        for (int b = 0; b < 4; b++) begin
            w = w | (((d >> (8 * (b % nb))) & 32'hFF) << (8 * b));
        end
        return w;
    endfunction

    function automatic logic [31:0] m_load(input int size, input int o, input bit sext,
                                           input logic [31:0] r);
        int              nb;
        longint unsigned mask;
        longint unsigned v;
        nb = 1 << size;
        if (nb >= 4) return r;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = (64'(r) >> (8 * o)) & mask;
        if (sext && v[8 * nb - 1]) v = v | (~mask & 64'hFFFF_FFFF);
        return 32'(v);
    endfunction

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Bus slave: holds bus_ready_i low for stall_cfg write cycles, random otherwise.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (bus_req_o && bus_we_o) begin
            bus_ready_i = (wr_seen >= stall_cfg);
            wr_seen++;
        end else begin
            wr_seen     = 0;
            bus_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares bus activity and load/store responses against the queues.
    initial forever begin
        bus_exp_t  e;
        resp_exp_t r;
        @(negedge clk_i);
        if (!rst_i) begin
            if (bus_req_o) begin
                if (bus_q.size() == 0) begin
                    flag("unexpected_bus_req", bus_addr_o);
                end else begin
                    e = bus_q[0];
                    check("bus_we", 32'(bus_we_o), 32'(e.we));
                    check("bus_addr", bus_addr_o, e.addr);
                    check("bus_be", 32'(bus_be_o), 32'(e.be));
                    if (e.we) check("bus_wdata", bus_wdata_o, e.wdata);
                    if (!bus_we_o || bus_ready_i) void'(bus_q.pop_front());
                end
            end
            if (rd_phase2) begin
                if (resp_q.size() == 0 || !resp_q[0].is_load) begin
                    flag("missing_load_resp", rdata_o);
                end else begin
                    r = resp_q.pop_front();
                    check("load_rdata", rdata_o, r.rdata);
                    check("load_err", 32'(err_o), 32'(r.err));
                end
                if (mem_wr_ready_o) flag("ready_during_load", 32'(mem_wr_ready_o));
            end else begin
                check("rdata_idle_zero", rdata_o, 32'h0);
                if (mem_wr_ready_o) begin
                    if (resp_q.size() == 0 || resp_q[0].is_load) begin
                        flag("unexpected_wr_ready", 32'(mem_wr_ready_o));
                    end else begin
                        r = resp_q.pop_front();
                        check("store_err", 32'(err_o), 32'(r.err));
                    end
                end else if (err_o) begin
                    flag("unexpected_err", 32'(err_o));
                end
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input int size, input bit sext,
                           input logic [31:0] rv);
        bus_exp_t  e;
        resp_exp_t r;
        bit        legal;
        legal = m_legal(size, a);
        if (legal) begin
            e.we = 1'b0; e.addr = a & ~32'h3; e.be = m_be(size, a); e.wdata = '0;
            bus_q.push_back(e);
        end
        r.is_load = 1'b1;
        r.rdata   = legal ? m_load(size, int'(a % 4), sext, rv) : 32'h0;
        r.err     = !legal;
        resp_q.push_back(r);
        mem_wr_en_i  = 1'b0;
        mem_r_en_i   = 1'b1;
        mem_acc_r_i  = 2'(size);
        mem_r_sext_i = sext;
        addr_i       = a;
        bus_rdata_i  = ~rv;
        @(posedge clk_i); #1;
        rd_phase2    = 1'b1;
        bus_rdata_i  = rv;
        addr_i       = $urandom;
        mem_acc_r_i  = 2'($urandom_range(0, 3));
        mem_r_sext_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        rd_phase2    = 1'b0;
        mem_r_en_i   = 1'b0;
        bus_rdata_i  = $urandom;
    endtask

    task automatic do_store(input logic [31:0] a, input int size, input logic [31:0] d,
                            input int stall);
        bus_exp_t  e;
        resp_exp_t r;
        bit        legal;
        bit        got;
        int        n;
        legal     = m_legal(size, a);
        stall_cfg = stall;
        if (legal) begin
            e.we = 1'b1; e.addr = a & ~32'h3; e.be = m_be(size, a); e.wdata = m_wdata(size, d);
            bus_q.push_back(e);
        end
        r.is_load = 1'b0;
        r.rdata   = '0;
        r.err     = !legal;
        resp_q.push_back(r);
        mem_wr_en_i  = 1'b1;
        mem_r_en_i   = 1'($urandom_range(0, 1));
        mem_acc_r_i  = 2'($urandom_range(0, 3));
        mem_acc_w_i  = 2'(size);
        addr_i       = a;
        wdata_i      = d;
        @(negedge clk_i);
        got = mem_wr_ready_o;
        @(posedge clk_i); #1;
        mem_r_en_i  = 1'b0;
        addr_i      = $urandom;
        wdata_i     = $urandom;
        mem_acc_w_i = 2'($urandom_range(0, 3));
        n = 1;
        while (!got && n < 64) begin
            @(negedge clk_i);
            if (mem_wr_ready_o) got = 1'b1;
            else n++;
        end
        check("store_latency", 32'(n), legal ? 32'(stall + 2) : 32'd1);
        @(posedge clk_i); #1;
        mem_wr_en_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdata"}, rdata_o, 32'h0);
        check({tag, "_ready"}, 32'(mem_wr_ready_o), 32'h0);
        check({tag, "_err"}, 32'(err_o), 32'h0);
        check({tag, "_req"}, 32'(bus_req_o), 32'h0);
        check({tag, "_we"}, 32'(bus_we_o), 32'h0);
        check({tag, "_addr"}, bus_addr_o, 32'h0);
        check({tag, "_be"}, 32'(bus_be_o), 32'h0);
        check({tag, "_wdata"}, bus_wdata_o, 32'h0);
    endtask

    initial begin
        #(300000);
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int          t0;
        int          size;
        int          gap;
        logic [31:0] a;

        mem_r_en_i = 1'b1;
        #12;
        check_outputs_zero("reset");
        mem_r_en_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Directed cases
        do_store(32'h104, 2, 32'hDEADBEEF, 0);
        do_store(32'h203, 0, 32'h000000A5, 3);
        do_load(32'h103, 0, 1'b1, 32'h80FF7F01);
        do_load(32'h101, 0, 1'b0, 32'h80FF7F01);
        do_load(32'h102, 1, 1'b1, 32'h80FF7F01);
        do_load(32'h100, 2, 1'b0, 32'h80FF7F01);
        do_load(32'h102, 2, 1'b0, 32'h80FF7F01);
        do_store(32'h101, 1, 32'h12345678, 0);
        do_load(32'h200, 3, 1'b0, 32'h55AA55AA);

        t0 = cyc;
        do_load(32'h300, 2, 1'b0, 32'hCAFEF00D);
        do_store(32'h304, 1, 32'hBEEF1234, 0);
        do_load(32'h306, 1, 1'b0, 32'h89ABCDEF);
        check("ld_st_ld_cycles", 32'(cyc - t0), 32'd7);

        // Reset while a write is stalled on the bus
        begin
            bus_exp_t e;
            stall_cfg = 100000;
            e.we = 1'b1; e.addr = 32'h300; e.be = 4'hF; e.wdata = 32'h11223344;
            bus_q.push_back(e);
            mem_wr_en_i = 1'b1;
            mem_acc_w_i = 2'd2;
            addr_i      = 32'h300;
            wdata_i     = 32'h11223344;
            @(posedge clk_i); #1;
            @(posedge clk_i); #1;
            @(negedge clk_i);
            #2;
            rst_i = 1'b1;
            #1;
            check("rst_async_req_drop", 32'(bus_req_o), 32'h0);
            check("rst_no_ready", 32'(mem_wr_ready_o), 32'h0);
            mem_wr_en_i = 1'b0;
            bus_q.delete();
            @(posedge clk_i); #1;
            check_outputs_zero("midreset");
            @(posedge clk_i); #1;
            rst_i     = 1'b0;
            stall_cfg = 0;
        end
        do_store(32'h308, 2, 32'h0BADF00D, 1);

        // Randomised mix of loads and stores
        for (int i = 0; i < 300; i++) begin
            int r;
            r    = $urandom_range(0, 9);
            size = (r < 9) ? (r % 3) : 3;
            a    = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << (size % 3)) - 32'd1);
            if ($urandom_range(0, 1) == 1)
                do_load(a, size, 1'($urandom_range(0, 1)), $urandom);
            else
                do_store(a, size, $urandom, $urandom_range(0, 3));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            repeat (gap) begin
                @(posedge clk_i); #1;
            end
        end

        repeat (4) @(posedge clk_i);
        #1;
        check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
